// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core.
// Parity modes, serializer/deserializer state encodings, default divider.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // 21.477 MHz / 115200 baud
    localparam int CLK_DIV_DEFAULT = 186;

    function automatic logic [7:0] data_mask(input int bits);
        return 8'((1 << bits) - 1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FWFT FIFO; pointers carry one extra wrap bit for full/empty.
// A push on a full FIFO succeeds only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_core.sv
// UART with TX/RX FIFOs, configurable data bits, parity and stop bits.
// RX samples mid-bit from a two-flop synchronized input.
module uart_core
    import uart_pkg::*;
#(
    parameter int      CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       ovr_clr,
    output logic       tx_idle,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int         CW        = 16;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [7:0] MASK      = data_mask(DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY == PAR_ODD);
    localparam logic       HAS_PAR   = (PARITY != PAR_NONE);

    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_push;
    logic       tx_pop;
    logic       rdy_q;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic          tx_stop_idx;
    logic [7:0]    tx_shift;
    logic          tx_par;
    logic          txd_q;
    logic          tx_bit_done;
    logic          tx_last_stop;

    assign tx_ready = rdy_q && !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign uart_txd = txd_q;
    assign tx_idle  = tx_empty && (tx_state == TX_IDLE);

    assign tx_bit_done  = (tx_cnt == DIV_LAST);
    assign tx_last_stop = (tx_state == TX_STOP) && tx_bit_done &&
                          (tx_stop_idx == LAST_STOP);
    assign tx_pop       = !tx_empty &&
                          ((tx_state == TX_IDLE) || tx_last_stop);

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (tx_data & MASK),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            if (tx_state == TX_IDLE || tx_bit_done) tx_cnt <= '0;
            else                                    tx_cnt <= tx_cnt + 1'b1;

            // Loading from IDLE or straight out of the last stop bit.
            if (tx_pop) begin
                tx_state <= TX_START;
                txd_q    <= 1'b0;
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ ODD;
                tx_cnt   <= '0;
            end else begin
                unique case (tx_state)
                    TX_IDLE: ;
                    TX_START: if (tx_bit_done) begin
                        tx_state <= TX_DATA;
                        txd_q    <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                    end
                    TX_DATA: if (tx_bit_done) begin
                        if (tx_bit == LAST_BIT) begin
                            if (HAS_PAR) begin
                                tx_state <= TX_PARITY;
                                txd_q    <= tx_par;
                            end else begin
                                tx_state    <= TX_STOP;
                                txd_q       <= 1'b1;
                                tx_stop_idx <= 1'b0;
                            end
                        end else begin
                            txd_q    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                    TX_PARITY: if (tx_bit_done) begin
                        tx_state    <= TX_STOP;
                        txd_q       <= 1'b1;
                        tx_stop_idx <= 1'b0;
                    end
                    TX_STOP: if (tx_bit_done) begin
                        if (tx_stop_idx == LAST_STOP) tx_state <= TX_IDLE;
                        else                          tx_stop_idx <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        txd_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic          rxd_s1;
    logic          rxd_s2;
    logic          rxd_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_perr_q;
    logic          rx_sample;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_empty;
    logic [9:0]    rx_word;
    logic [9:0]    rx_head;
    logic          ovr_q;

    assign rx_sample = (rx_state == RX_START) ? (rx_cnt == HALF_LAST)
                                              : (rx_cnt == DIV_LAST);
    assign rx_push   = (rx_state == RX_STOP) && rx_sample;
    assign rx_word   = {~rxd_s2, rx_perr_q, rx_shift};
    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_ready && rx_valid;

    assign rx_data    = rx_valid ? rx_head[7:0] : 8'h00;
    assign rx_perr    = rx_valid && rx_head[8];
    assign rx_ferr    = rx_valid && rx_head[9];
    assign rx_overrun = ovr_q;

    uart_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1    <= 1'b1;
            rxd_s2    <= 1'b1;
            rxd_prev  <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_perr_q <= 1'b0;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
            else                                  rx_cnt <= rx_cnt + 1'b1;

            unique case (rx_state)
                RX_IDLE: if (rxd_prev && !rxd_s2) begin
                    rx_state  <= RX_START;
                    rx_shift  <= '0;
                    rx_perr_q <= 1'b0;
                end
                // A line back at 1 at mid-start is treated as a glitch.
                RX_START: if (rx_sample) begin
                    rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    rx_bit   <= '0;
                end
                RX_DATA: if (rx_sample) begin
                    rx_shift[rx_bit] <= rxd_s2;
                    if (rx_bit == LAST_BIT)
                        rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                    else
                        rx_bit <= rx_bit + 1'b1;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_perr_q <= (^rx_shift) ^ rxd_s2 ^ ODD;
                    rx_state  <= RX_STOP;
                end
                RX_STOP: if (rx_sample) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Setting wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               ovr_q <= 1'b0;
        else if (rx_push && rx_full && !rx_pop)   ovr_q <= 1'b1;
        else if (ovr_clr)                         ovr_q <= 1'b0;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 186, clocks per bit period (21.477 MHz / 115200), legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-003 SHALL have parameter PARITY, default PAR_NONE, of type uart_pkg::parity_t {PAR_NONE, PAR_EVEN, PAR_ODD}.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of TX stop bits, legal values 1..2; RX checks only the first stop bit.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, entries per FIFO, power of two, legal range 2..256.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-009 tx_valid  in  1  tx_data is valid.
REQ-010 tx_ready  out  1  TX FIFO not full.
REQ-011 rx_data  out  8  RX FIFO head; unused high bits read 0.
REQ-012 rx_perr  out  1  parity error flag of the head entry.
REQ-013 rx_ferr  out  1  framing error flag of the head entry.
REQ-014 rx_valid  out  1  RX FIFO not empty.
REQ-015 rx_ready  in  1  pops the head entry.
REQ-016 rx_overrun  out  1  sticky flag: a frame was dropped.
REQ-017 ovr_clr  in  1  clears rx_overrun.
REQ-018 tx_idle  out  1  TX FIFO empty and serializer in IDLE.
REQ-019 uart_rxd  in  1  asynchronous serial input; idle level 1.
REQ-020 uart_txd  out  1  serial output; idle level 1.

Function
REQ-021 TX push SHALL occur on a cycle with tx_valid && tx_ready; while full, tx_ready=0 and the push is refused even if a pop occurs in the same cycle.
REQ-022 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; from IDLE with the FIFO non-empty, it SHALL pop the FIFO and drive start (0) on the next cycle.
REQ-023 Every TX bit SHALL last exactly CLK_DIV clocks; data goes out LSB first; PARITY is skipped when PAR_NONE; STOP lasts STOP_BITS*CLK_DIV clocks at level 1.
REQ-024 After STOP, TX SHALL go to IDLE, or straight to START if the FIFO is non-empty, with no extra idle bit.
REQ-025 Parity bit SHALL be the XOR of the data bits for PAR_EVEN and its inverse for PAR_ODD.
REQ-026 uart_rxd SHALL pass through a two-flop synchronizer; all RX decisions use the synchronized signal.
REQ-027 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a 1->0 transition in IDLE enters START.
REQ-028 RX SHALL re-sample at CLK_DIV/2 clocks after the edge; if the line is 1, RX returns to IDLE with no push (glitch reject).
REQ-029 RX SHALL sample each subsequent bit every CLK_DIV clocks from the start-bit midpoint.
REQ-030 A stop sample of 0 SHALL set the entry's ferr; a parity mismatch SHALL set the entry's perr; the entry is pushed regardless.
REQ-031 After the stop sample, RX SHALL return to IDLE immediately so that back-to-back frames are received.
REQ-032 An RX push onto a full FIFO with no simultaneous pop SHALL drop the entry and set rx_overrun; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-033 rx_ready while rx_valid=0 SHALL be ignored; rx_data/rx_perr/rx_ferr are first-word-fall-through.
REQ-034 A set and a clear of rx_overrun in the same cycle SHALL leave it set.

Reset
REQ-035 rst_n low SHALL asynchronously force: uart_txd=1, tx_ready=0, tx_idle=1, rx_valid=0, rx_overrun=0, rx_data/perr/ferr=0, both FSMs to IDLE, FIFOs empty, synchronizer flops to 1.
REQ-036 tx_ready SHALL rise the first cycle after rst_n deasserts; reset mid-frame truncates the frame without emitting a glitch below 1 after reset.

Structure
REQ-037 uart_pkg SHALL hold parity_t, the TX/RX state enums, and the CLK_DIV default.
REQ-038 A single sub-module uart_fifo (parameters WIDTH, DEPTH; wrapping pointers plus one extra wrap bit for full/empty) SHALL be instantiated twice: TX with width 8, RX with width 10.

Verification
REQ-039 Defaults, CLK_DIV=16; push 0x55 -> uart_txd reads 0,1,0,1,0,1,0,1,0,1, each bit 16 clocks, then tx_idle=1.
REQ-040 Loop uart_txd to uart_rxd with PAR_EVEN; push 0xA3, 0x00, 0xFF back-to-back -> three RX entries with the same data, perr=0, ferr=0.
REQ-041 Inject a 0x41 frame with the stop bit forced to 0 -> rx_data=0x41, rx_ferr=1; a 3-clock low glitch -> no entry.
REQ-042 FIFO_DEPTH=4; receive 5 frames with rx_ready=0 -> rx_valid=1, 4 entries, rx_overrun=1; ovr_clr -> 0.
REQ-043 Assert rst_n low mid-DATA -> uart_txd=1 immediately, tx_idle=1; after release, a new byte is sent correctly.
